truth_table_sweeper: RTL

//   Sequential checker that drives every N-bit input vector into M pairs of

---
 rtl/truth_table_sweeper.sv | 110 +++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps every N-bit input vector through M ref/simp function pairs and
// accumulates mismatch statistics into a pass/fail summary.
module truth_table_sweeper #(
   parameter int N = 3,
   parameter int M = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [N-1:0] vec,
   input  logic [M-1:0] ref_out,
   input  logic [M-1:0] simp_out,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_count,
   output logic [M-1:0] fail_mask,
   output logic [N-1:0] first_fail_vec,
   output logic         first_fail_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [N-1:0] VEC_LAST = {N{1'b1}};
   localparam logic [N:0]   ERR_ONE  = {{N{1'b0}}, 1'b1};

   state_t         state_q, state_d;
   logic [N-1:0]   vec_q, vec_d;
   logic [N:0]     err_q, err_d;
   logic [M-1:0]   mask_q, mask_d;
   logic [N-1:0]   ffv_q, ffv_d;
   logic           ffvalid_q, ffvalid_d;
   logic           pass_q, pass_d;
   logic [M-1:0]   diff;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         vec_q     <= '0;
         err_q     <= '0;
         mask_q    <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         err_q     <= err_d;
         mask_q    <= mask_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         pass_q    <= pass_d;
      end
   end

   // ref/simp are only looked at in RUN, so junk on them elsewhere is harmless
   assign diff = ref_out ^ simp_out;

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      err_d     = err_q;
      mask_d    = mask_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
      pass_d    = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_RUN;
               vec_d     = '0;
               err_d     = '0;
               mask_d    = '0;
               ffvalid_d = 1'b0;
               pass_d    = 1'b0;
            end
         end
         S_RUN: begin
            mask_d = mask_q | diff;
            if (|diff) begin
               err_d = err_q + ERR_ONE;
               if (!ffvalid_q) begin
                  ffv_d     = vec_q;
                  ffvalid_d = 1'b1;
               end
            end
            vec_d = vec_q + 1'b1;
            if (vec_q == VEC_LAST) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign vec              = vec_q;
   assign busy             = (state_q == S_RUN);
   assign done             = (state_q == S_DONE);
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign fail_mask        = mask_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;

endmodule
